// File: rtl/cache_sim_pkg.sv
// Shared definitions for the cacheSim statistics collector: ratio scaling,
// the counter record layout and the report FSM state encoding.
package cache_sim_pkg;

    // Full-scale ratio (100.00%) and the width needed to hold it.
    localparam int RATIO_SCALE = 10000;
    localparam int RATIO_W     = 14;

    // Counter width used by the default build and by consumers of the record.
    localparam int STATS_CNT_W = 32;

    // One complete set of run counters, as exported to downstream consumers.
    typedef struct packed {
        logic [STATS_CNT_W-1:0] accesses;
        logic [STATS_CNT_W-1:0] reads;
        logic [STATS_CNT_W-1:0] writes;
        logic [STATS_CNT_W-1:0] hits;
        logic [STATS_CNT_W-1:0] misses;
        logic [STATS_CNT_W-1:0] evictions;
        logic [STATS_CNT_W-1:0] writebacks;
    } cache_stats_t;

    // Ratio report sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } stats_state_e;

endpackage

// File: rtl/ratio_divider.sv
// Sequential restoring divider: one quotient bit per clock, NUM_W clocks per
// divide. o_done is high during the final iteration; o_quot holds the full
// quotient from the following cycle until the next i_start.
module ratio_divider #(
    parameter int NUM_W = 46,
    parameter int DEN_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_numer,
    input  logic [DEN_W-1:0] i_denom,
    output logic             o_done,
    output logic [NUM_W-1:0] o_quot
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] r_quot;
    logic [DEN_W-1:0] r_rem;
    logic [DEN_W-1:0] r_den;
    logic [CNT_W-1:0] r_count;

    logic [DEN_W:0]   w_shifted;
    logic             w_fits;
    logic [DEN_W-1:0] w_diff;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        w_shifted = {r_rem, r_quot[NUM_W-1]};
        w_fits    = (w_shifted >= {1'b0, r_den});
        w_diff    = w_shifted[DEN_W-1:0] - r_den;
    end

    // Load operands on start, then retire one quotient bit per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_quot  <= '0;
            r_rem   <= '0;
            r_den   <= '0;
            r_count <= '0;
        end else if (i_start) begin
            r_quot  <= i_numer;
            r_rem   <= '0;
            r_den   <= i_denom;
            r_count <= CNT_W'(NUM_W);
        end else if (r_count != '0) begin
            r_rem   <= w_fits ? w_diff : w_shifted[DEN_W-1:0];
            r_quot  <= {r_quot[NUM_W-2:0], w_fits};
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done = (r_count == CNT_W'(1));
    assign o_quot = r_quot;

endmodule

// File: rtl/cache_stats_collector.sv
// Run counters for cacheSim access outcomes plus an on-demand hit/miss ratio
// report in hundredths of a percent.
// Build option CACHE_STATS_SAT_EN: counters saturate at all-ones and the
// first saturation sets protocol_err; otherwise counters wrap.
module cache_stats_collector
    import cache_sim_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_valid,
    input  logic                 acc_rw,
    input  logic                 acc_hit,
    input  logic                 acc_evict,
    input  logic                 acc_writeback,
    input  logic                 clear,
    input  logic                 report_req,
    output logic [CNT_WIDTH-1:0] accesses,
    output logic [CNT_WIDTH-1:0] reads,
    output logic [CNT_WIDTH-1:0] writes,
    output logic [CNT_WIDTH-1:0] hits,
    output logic [CNT_WIDTH-1:0] misses,
    output logic [CNT_WIDTH-1:0] evictions,
    output logic [CNT_WIDTH-1:0] writebacks,
    output logic                 busy,
    output logic                 report_valid,
    output logic [RATIO_W-1:0]   hit_ratio,
    output logic [RATIO_W-1:0]   miss_ratio,
    output logic                 protocol_err
);

    localparam int NUM_W = CNT_WIDTH + RATIO_W;

    logic [CNT_WIDTH-1:0] r_accesses, r_reads, r_writes, r_hits, r_misses, r_evictions, r_writebacks;
    logic [CNT_WIDTH-1:0] w_nAcc, w_nRd, w_nWr, w_nHit, w_nMiss, w_nEvict, w_nWb;
    logic                 w_incRd, w_incWr, w_incHit, w_incMiss, w_incEvict, w_incWb;
    logic                 w_illegal, w_satEvent;
    logic                 r_protoErr;

    stats_state_e         r_state;
    logic [CNT_WIDTH-1:0] r_snapHits, r_snapAcc;
    logic                 r_busy, r_reportValid;
    logic [RATIO_W-1:0]   r_hitRatio, r_missRatio;

    logic [NUM_W-1:0]     w_numer, w_quot;
    logic                 w_divStart, w_divDone;
    logic [RATIO_W-1:0]   w_ratio;

    // Increment one counter; in the saturating build an all-ones counter holds.
    function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v, input logic en);
`ifdef CACHE_STATS_SAT_EN
        if (&v)
            return v;
`endif
        return v + CNT_WIDTH'(en);
    endfunction

    // Per-counter increment enables and illegal strobe detection.
    always_comb begin
        w_incRd    = acc_valid & ~acc_rw;
        w_incWr    = acc_valid & acc_rw;
        w_incHit   = acc_valid & acc_hit;
        w_incMiss  = acc_valid & ~acc_hit;
        w_incEvict = acc_valid & acc_evict;
        w_incWb    = acc_valid & acc_evict & acc_writeback;
        w_illegal  = ~clear & acc_valid &
                     ((acc_writeback & ~acc_evict) | (acc_evict & acc_hit));
    end

`ifdef CACHE_STATS_SAT_EN
    // A saturation event is an increment request against an all-ones counter.
    always_comb begin
        w_satEvent = ~clear & ((acc_valid  & (&r_accesses))  | (w_incRd    & (&r_reads))     |
                               (w_incWr    & (&r_writes))    | (w_incHit   & (&r_hits))      |
                               (w_incMiss  & (&r_misses))    | (w_incEvict & (&r_evictions)) |
                               (w_incWb    & (&r_writebacks)));
    end
`else
    assign w_satEvent = 1'b0;
`endif

    // Counter next-state values; clear overrides any same-cycle access.
    always_comb begin
        w_nAcc   = '0;
        w_nRd    = '0;
        w_nWr    = '0;
        w_nHit   = '0;
        w_nMiss  = '0;
        w_nEvict = '0;
        w_nWb    = '0;
        if (!clear) begin
            w_nAcc   = bump(r_accesses,   acc_valid);
            w_nRd    = bump(r_reads,      w_incRd);
            w_nWr    = bump(r_writes,     w_incWr);
            w_nHit   = bump(r_hits,       w_incHit);
            w_nMiss  = bump(r_misses,     w_incMiss);
            w_nEvict = bump(r_evictions,  w_incEvict);
            w_nWb    = bump(r_writebacks, w_incWb);
        end
    end

    // Counter registers and the sticky protocol error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_accesses   <= '0;
            r_reads      <= '0;
            r_writes     <= '0;
            r_hits       <= '0;
            r_misses     <= '0;
            r_evictions  <= '0;
            r_writebacks <= '0;
            r_protoErr   <= 1'b0;
        end else begin
            r_accesses   <= w_nAcc;
            r_reads      <= w_nRd;
            r_writes     <= w_nWr;
            r_hits       <= w_nHit;
            r_misses     <= w_nMiss;
            r_evictions  <= w_nEvict;
            r_writebacks <= w_nWb;
            r_protoErr   <= r_protoErr | w_illegal | w_satEvent;
        end
    end

    // The divider starts from LOAD only for a non-zero divisor. After a wrap
    // hits can exceed accesses, so the quotient is clamped to full scale.
    always_comb begin
        w_numer    = NUM_W'(r_snapHits) * NUM_W'(RATIO_SCALE);
        w_divStart = (r_state == ST_LOAD) && (r_snapAcc != '0);
        w_ratio    = '0;
        if (r_snapAcc != '0) begin
            if (w_quot > NUM_W'(RATIO_SCALE))
                w_ratio = RATIO_W'(RATIO_SCALE);
            else
                w_ratio = w_quot[RATIO_W-1:0];
        end
    end

    ratio_divider #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_WIDTH)
    ) u_divider (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_divStart),
        .i_numer (w_numer),
        .i_denom (r_snapAcc),
        .o_done  (w_divDone),
        .o_quot  (w_quot)
    );

    // Report sequencer: snapshot, divide, publish ratios with a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_snapHits    <= '0;
            r_snapAcc     <= '0;
            r_busy        <= 1'b0;
            r_reportValid <= 1'b0;
            r_hitRatio    <= '0;
            r_missRatio   <= '0;
        end else begin
            r_reportValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (report_req) begin
                        r_snapHits <= w_nHit;
                        r_snapAcc  <= w_nAcc;
                        r_busy     <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= (r_snapAcc == '0) ? ST_DONE : ST_DIV;
                end
                ST_DIV: begin
                    if (w_divDone)
                        r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_reportValid <= 1'b1;
                    r_hitRatio    <= w_ratio;
                    r_missRatio   <= (r_snapAcc == '0) ? '0 : RATIO_W'(RATIO_SCALE) - w_ratio;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign accesses     = r_accesses;
    assign reads        = r_reads;
    assign writes       = r_writes;
    assign hits         = r_hits;
    assign misses       = r_misses;
    assign evictions    = r_evictions;
    assign writebacks   = r_writebacks;
    assign protocol_err = r_protoErr;
    assign busy         = r_busy;
    assign report_valid = r_reportValid;
    assign hit_ratio    = r_hitRatio;
    assign miss_ratio   = r_missRatio;

endmodule
